// File: rtl/bram_arbiter_pkg.sv
// configure: shared types for the BRAM arbiter slice.
//   bram_depth  - BRAM depth in 32-bit words (address decode width)
//   mem_req_t   - one captured memory request
//   arb_owner_t - which side owns the BRAM response next cycle
//   slot_st_t   - per-side request slot state
package configure;

  localparam int bram_depth = 1024;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } arb_owner_t;

  typedef enum logic {
    SLOT_EMPTY   = 1'b0,
    SLOT_PENDING = 1'b1
  } slot_st_t;

endpackage

// File: rtl/bram_arbiter_slot.sv
// bram_arbiter_slot: one-entry capture/bypass buffer for one requester.
//
// state        | meaning
// SLOT_EMPTY   | nothing held; an incoming pulse is presented directly (bypass)
// SLOT_PENDING | a request lost arbitration and is held until granted
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req_in     - incoming request (valid is a one-cycle pulse)
//   grant      - the eligible request is issued to BRAM this cycle
//   eligible   - request competing for the BRAM this cycle
//   pending    - slot holds a request
module bram_arbiter_slot
  import configure::*;
(
  input  logic     clk,
  input  logic     rst,
  input  mem_req_t req_in,
  input  logic     grant,
  output mem_req_t eligible,
  output logic     pending
);

  slot_st_t state, state_next;
  mem_req_t held;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      held  <= '0;
    end else begin
      state <= state_next;
      if (state == SLOT_EMPTY && req_in.valid && !grant)
        held <= req_in;
    end
  end

  // A pulse arriving while PENDING is a protocol violation and is dropped:
  // the held request keeps being presented.
  always_comb begin
    state_next = state;
    eligible   = req_in;
    case (state)
      SLOT_EMPTY: begin
        if (req_in.valid && !grant)
          state_next = SLOT_PENDING;
      end
      SLOT_PENDING: begin
        eligible = held;
        if (grant)
          state_next = SLOT_EMPTY;
      end
      default: state_next = SLOT_EMPTY;
    endcase
  end

  assign pending = (state == SLOT_PENDING);

endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one BRAM port between fetch (imem) and load/store (dmem).
// Each side gets one-cycle latency when uncontested; dmem wins conflicts unless
// BRAM_ARB_ROUND_ROBIN_EN is defined, in which case a last-grant pointer
// alternates priority.
//
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   imem_valid/instr/addr/wdata/wstrb - fetch request (valid = 1-cycle pulse)
//   imem_rdata, imem_ready            - fetch response
//   dmem_*                            - same set for the data side
//   bram_valid/instr/addr/wdata/wstrb - granted request to BRAM
//   bram_rdata, bram_ready            - BRAM response, one cycle after issue
module bram_arbiter
  import configure::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic        imem_instr,
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  input  logic [3:0]  imem_wstrb,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic        dmem_instr,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        bram_valid,
  output logic        bram_instr,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  output logic [3:0]  bram_wstrb,
  input  logic [31:0] bram_rdata,
  input  logic        bram_ready
);

  mem_req_t   req_i, req_d, elig_i, elig_d, bram_req;
  logic       pend_i, pend_d;
  logic       grant_i, grant_d;
  arb_owner_t owner, owner_next;

  assign req_i = '{valid: imem_valid, instr: imem_instr, addr: imem_addr,
                   wdata: imem_wdata, wstrb: imem_wstrb};
  assign req_d = '{valid: dmem_valid, instr: dmem_instr, addr: dmem_addr,
                   wdata: dmem_wdata, wstrb: dmem_wstrb};

  bram_arbiter_slot u_slot_imem (
    .clk(clk), .rst(rst), .req_in(req_i), .grant(grant_i),
    .eligible(elig_i), .pending(pend_i)
  );

  bram_arbiter_slot u_slot_dmem (
    .clk(clk), .rst(rst), .req_in(req_d), .grant(grant_d),
    .eligible(elig_d), .pending(pend_d)
  );

`ifdef BRAM_ARB_ROUND_ROBIN_EN
  // 1 = dmem was granted last; resets to dmem so imem wins the first contest.
  logic last_dmem;

  always_ff @(posedge clk) begin
    if (rst)
      last_dmem <= 1'b1;
    else if (grant_i || grant_d)
      last_dmem <= grant_d;
  end
`endif

  always_comb begin
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    bram_req = '0;
    if (!rst) begin
`ifdef BRAM_ARB_ROUND_ROBIN_EN
      if (elig_i.valid && elig_d.valid) begin
        grant_i = last_dmem;
        grant_d = !last_dmem;
      end else begin
        grant_i = elig_i.valid;
        grant_d = elig_d.valid;
      end
`else
      grant_d = elig_d.valid;
      grant_i = elig_i.valid && !elig_d.valid;
`endif
    end
    if (grant_d)
      bram_req = elig_d;
    else if (grant_i)
      bram_req = elig_i;
  end

  always_comb begin
    owner_next = OWN_NONE;
    if (grant_d)
      owner_next = OWN_DMEM;
    else if (grant_i)
      owner_next = OWN_IMEM;
  end

  always_ff @(posedge clk) begin
    if (rst)
      owner <= OWN_NONE;
    else
      owner <= owner_next;
  end

  assign bram_valid = grant_i || grant_d;
  assign bram_instr = bram_req.instr;
  assign bram_addr  = bram_req.addr;
  assign bram_wdata = bram_req.wdata;
  assign bram_wstrb = bram_req.wstrb;

  // Ready is gated by rst so a response to a pre-reset access never escapes.
  assign imem_ready = bram_ready && (owner == OWN_IMEM) && !rst;
  assign dmem_ready = bram_ready && (owner == OWN_DMEM) && !rst;
  assign imem_rdata = bram_rdata;
  assign dmem_rdata = bram_rdata;

  // A requester must not pulse while its previous request is still held.
  a_imem_no_overrun: assert property (@(posedge clk) disable iff (rst)
                                      !(pend_i && imem_valid));
  a_dmem_no_overrun: assert property (@(posedge clk) disable iff (rst)
                                      !(pend_d && dmem_valid));

endmodule
